// File: rtl/smart_merge_drain.sv
// Drains the valid head prefixes of parallel FIFOs into one registered output bundle,
// visiting FIFOs round-robin and tagging each lane with its source FIFO index.
module smart_merge_drain #(
    parameter int unsigned FIFOS        = 2,
    parameter int unsigned INPUT_PORTS  = 2,
    parameter int unsigned OUTPUT_PORTS = 2,
    parameter int unsigned DATA_WIDTH   = 32,
    localparam int unsigned TAG_W       = (FIFOS > 1) ? $clog2(FIFOS) : 1
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  flush,
    input  logic [FIFOS-1:0][INPUT_PORTS-1:0]                     valid_in,
    input  logic [FIFOS-1:0][INPUT_PORTS-1:0][DATA_WIDTH-1:0]     data_in,
    output logic [FIFOS-1:0][INPUT_PORTS-1:0]                     pop,
    output logic [OUTPUT_PORTS-1:0]                               valid_out,
    output logic [OUTPUT_PORTS-1:0][DATA_WIDTH-1:0]               data_out,
    output logic [OUTPUT_PORTS-1:0][TAG_W-1:0]                    tag_out,
    input  logic                                                  ready_in
);

    localparam int unsigned LANE_W = (OUTPUT_PORTS > 1) ? $clog2(OUTPUT_PORTS) : 1;

    logic [TAG_W-1:0]                            rr_ptr;
    logic                                        loadable;
    logic                                        do_sel;
    logic [OUTPUT_PORTS-1:0]                     sel_valid;
    logic [OUTPUT_PORTS-1:0][DATA_WIDTH-1:0]     sel_data;
    logic [OUTPUT_PORTS-1:0][TAG_W-1:0]          sel_tag;
    logic [LANE_W:0]                             lane_cnt;
    logic [TAG_W:0]                              fifo_sum;
    logic [TAG_W-1:0]                            fifo_idx;
    logic [TAG_W-1:0]                            last_fifo;
    logic                                        any_pop;
    logic                                        prefix_ok;
    logic [TAG_W:0]                              ptr_sum;
    logic [TAG_W-1:0]                            rr_next;

    assign loadable = ~(|valid_out) | ready_in;
    assign do_sel   = loadable & ~flush & ~rst;

    // Walk FIFOs from rr_ptr, taking each FIFO's contiguous valid prefix until lanes run out.
    always_comb begin
        pop       = '0;
        sel_valid = '0;
        sel_data  = '0;
        sel_tag   = '0;
        lane_cnt  = '0;
        fifo_sum  = '0;
        fifo_idx  = '0;
        last_fifo = rr_ptr;
        any_pop   = 1'b0;
        prefix_ok = 1'b0;
        if (do_sel) begin
            for (int k = 0; k < int'(FIFOS); k++) begin
                fifo_sum = {1'b0, rr_ptr} + (TAG_W + 1)'(k);
                if (fifo_sum >= (TAG_W + 1)'(FIFOS)) begin
                    fifo_sum = fifo_sum - (TAG_W + 1)'(FIFOS);
                end
                fifo_idx  = fifo_sum[TAG_W-1:0];
                prefix_ok = 1'b1;
                for (int s = 0; s < int'(INPUT_PORTS); s++) begin
                    prefix_ok = prefix_ok & valid_in[fifo_idx][s];
                    if (prefix_ok && (lane_cnt < (LANE_W + 1)'(OUTPUT_PORTS))) begin
                        pop[fifo_idx][s]                = 1'b1;
                        sel_valid[lane_cnt[LANE_W-1:0]] = 1'b1;
                        sel_data[lane_cnt[LANE_W-1:0]]  = data_in[fifo_idx][s];
                        sel_tag[lane_cnt[LANE_W-1:0]]   = fifo_idx;
                        lane_cnt                        = lane_cnt + (LANE_W + 1)'(1);
                        last_fifo                       = fifo_idx;
                        any_pop                         = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        ptr_sum = {1'b0, last_fifo} + (TAG_W + 1)'(1);
        if (ptr_sum >= (TAG_W + 1)'(FIFOS)) begin
            ptr_sum = '0;
        end
        rr_next = ptr_sum[TAG_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= '0;
            data_out  <= '0;
            tag_out   <= '0;
            rr_ptr    <= '0;
        end else if (flush) begin
            valid_out <= '0;
        end else if (loadable) begin
            valid_out <= sel_valid;
            data_out  <= sel_data;
            tag_out   <= sel_tag;
            if (any_pop) begin
                rr_ptr <= rr_next;
            end
        end
    end

endmodule

// File: tb/tb_smart_merge_drain.sv
// Scoreboard bench for smart_merge_drain: a reference model predicts pops and the next
// output bundle each cycle; predictions are queued and compared after the clock edge.
module tb_smart_merge_drain;

    localparam int F  = 2;
    localparam int P  = 2;
    localparam int O  = 2;
    localparam int W  = 32;
    localparam int TW = 1;

    typedef struct packed {
        logic [O-1:0]         v;
        logic [O-1:0][W-1:0]  d;
        logic [O-1:0][TW-1:0] t;
    } bundle_t;

    logic                         clk;
    logic                         rst;
    logic                         flush;
    logic [F-1:0][P-1:0]          valid_in;
    logic [F-1:0][P-1:0][W-1:0]   data_in;
    logic [F-1:0][P-1:0]          pop;
    logic [O-1:0]                 valid_out;
    logic [O-1:0][W-1:0]          data_out;
    logic [O-1:0][TW-1:0]         tag_out;
    logic                         ready_in;

    smart_merge_drain #(
        .FIFOS(F), .INPUT_PORTS(P), .OUTPUT_PORTS(O), .DATA_WIDTH(W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in), .data_in(data_in),
        .pop(pop), .valid_out(valid_out), .data_out(data_out), .tag_out(tag_out),
        .ready_in(ready_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int      n_tests = 0;
    int      n_fail  = 0;
    bundle_t sb_q[$];
    bundle_t exp_out;
    int      exp_rr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_select(input logic [F-1:0][P-1:0] v, input logic [F-1:0][P-1:0][W-1:0] d,
                                input int rr, output logic [F-1:0][P-1:0] p,
                                output bundle_t b, output int nrr);
        int n;
        int f;
        n   = 0;
        p   = '0;
        b   = '0;
        nrr = rr;
        for (int k = 0; k < F; k++) begin
            f = (rr + k) % F;
            for (int s = 0; s < P; s++) begin
                if (!v[f][s]) break;
                if (n < O) begin
                    p[f][s] = 1'b1;
                    b.v[n]  = 1'b1;
                    b.d[n]  = d[f][s];
                    b.t[n]  = TW'(f);
                    n++;
                    nrr = (f + 1) % F;
                end
            end
        end
    endtask

    // One clock: drive inputs, predict at the falling edge, compare registers after the rise.
    task automatic cycle(input logic r, input logic fl, input logic rdy,
                         input logic [F-1:0][P-1:0] v, input logic [F-1:0][P-1:0][W-1:0] d);
        logic [F-1:0][P-1:0] exp_pop;
        bundle_t             sel;
        bundle_t             got;
        int                  nrr;
        rst      = r;
        flush    = fl;
        ready_in = rdy;
        valid_in = v;
        data_in  = d;
        @(negedge clk);
        exp_pop = '0;
        if (r) begin
            exp_out = '0;
            exp_rr  = 0;
        end else if (fl) begin
            exp_out.v = '0;
        end else if ((exp_out.v == '0) || rdy) begin
            model_select(v, d, exp_rr, exp_pop, sel, nrr);
            exp_out = sel;
            exp_rr  = nrr;
        end
        check("pop", 64'(pop), 64'(exp_pop));
        sb_q.push_back(exp_out);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'(0), 64'(1));
        end else begin
            got = sb_q.pop_front();
            check("valid_out", 64'(valid_out), 64'(got.v));
            for (int l = 0; l < O; l++) begin
                if (got.v[l]) begin
                    check($sformatf("data_out[%0d]", l), 64'(data_out[l]), 64'(got.d[l]));
                    check($sformatf("tag_out[%0d]", l), 64'(tag_out[l]), 64'(got.t[l]));
                end
            end
        end
    endtask

    function automatic logic [F-1:0][P-1:0][W-1:0] mk(input logic [W-1:0] a0, input logic [W-1:0] a1,
                                                      input logic [W-1:0] b0, input logic [W-1:0] b1);
        logic [F-1:0][P-1:0][W-1:0] d;
        d[0][0] = a0;
        d[0][1] = a1;
        d[1][0] = b0;
        d[1][1] = b1;
        return d;
    endfunction

    initial begin
        logic [F-1:0][P-1:0]        v;
        logic [F-1:0][P-1:0][W-1:0] d;
        exp_out  = '0;
        exp_rr   = 0;
        rst      = 1'b1;
        flush    = 1'b0;
        ready_in = 1'b0;
        valid_in = '0;
        data_in  = '0;
        @(posedge clk);
        #1;
        // Reset and idle
        repeat (2) cycle(1'b1, 1'b0, 1'b1, '0, '0);
        repeat (3) cycle(1'b0, 1'b0, 1'b1, '0, '0);
        // FIFO0 {A0,A1}, FIFO1 {B0}: FIFO0 fills both lanes
        v = '0; v[0] = 2'b11; v[1] = 2'b01;
        cycle(1'b0, 1'b0, 1'b1, v, mk(32'hA0, 32'hA1, 32'hB0, 32'h0));
        // rr now at FIFO1: B0 then A2
        cycle(1'b0, 1'b0, 1'b1, v, mk(32'hA2, 32'hA3, 32'hB0, 32'h0));
        cycle(1'b0, 1'b0, 1'b1, '0, '0);
        // Gap: only slot1 of FIFO0 valid, never popped
        v = '0; v[0] = 2'b10;
        repeat (2) cycle(1'b0, 1'b0, 1'b1, v, mk(32'hDEAD, 32'hA9, 32'h0, 32'h0));
        // Backpressure
        v = '0; v[0] = 2'b11;
        cycle(1'b0, 1'b0, 1'b1, v, mk(32'hA4, 32'hA5, 32'h0, 32'h0));
        v[1] = 2'b01;
        repeat (3) cycle(1'b0, 1'b0, 1'b0, v, mk(32'hA6, 32'hA7, 32'hB1, 32'h0));
        cycle(1'b0, 1'b0, 1'b1, v, mk(32'hA6, 32'hA7, 32'hB1, 32'h0));
        // Flush beats ready and data; then reset mid-bundle
        v = '0; v[0] = 2'b11; v[1] = 2'b11;
        d = mk(32'hC0, 32'hC1, 32'hD0, 32'hD1);
        cycle(1'b0, 1'b1, 1'b1, v, d);
        cycle(1'b0, 1'b0, 1'b1, v, d);
        cycle(1'b1, 1'b0, 1'b0, v, d);
        cycle(1'b0, 1'b0, 1'b0, v, mk(32'hE0, 32'hE1, 32'hF0, 32'hF1));
        cycle(1'b0, 1'b0, 1'b0, '0, '0);
        // Random mix
        for (int i = 0; i < 400; i++) begin
            for (int f = 0; f < F; f++) begin
                v[f] = P'($urandom_range(0, (1 << P) - 1));
                for (int s = 0; s < P; s++) d[f][s] = $urandom;
            end
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 3) != 0), v, d);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/smart_merge_drain.md
Name: smart_merge_drain

Overview:
- Return-path counterpart of the multi-FIFO dispatch flow control: drains the heads of FIFOS parallel FIFOs and merges them into one registered OUTPUT_PORTS-wide bundle.
- Sits downstream of the per-unit FIFOs, e.g. in front of writeback/commit.
- Pops up to OUTPUT_PORTS entries per cycle across the FIFOs, with round-robin priority between FIFOs and in-order draining within each FIFO.
- Tags every output lane with its source FIFO index.

Parameters:
- FIFOS, 2, number of source FIFOs (>=1).
- INPUT_PORTS, 2, head entries visible per FIFO (>=1).
- OUTPUT_PORTS, 2, lanes in the output bundle (>=1).
- DATA_WIDTH, 32, entry width.
- TAG_W (localparam), max(1, $clog2(FIFOS)), source tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  drop the output bundle and pop nothing this cycle.
- valid_in  in  [FIFOS][INPUT_PORTS]  head-slot valids per FIFO; slot 0 = oldest.
- data_in  in  [FIFOS][INPUT_PORTS][DATA_WIDTH]  head-slot data.
- pop  out  [FIFOS][INPUT_PORTS]  combinational pop per head slot.
- valid_out  out  [OUTPUT_PORTS]  registered lane valids; lanes are packed from lane 0.
- data_out  out  [OUTPUT_PORTS][DATA_WIDTH]  registered lane data.
- tag_out  out  [OUTPUT_PORTS][TAG_W]  registered source FIFO index per lane.
- ready_in  in  1  consumer accepts the entire bundle this cycle.

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high.
- Reset: valid_out=0, data_out=0, tag_out=0, rr_ptr=0. pop=0 while rst is high.
- Output stage is one register bank. It is loadable when no valid_out lane is set, or when ready_in=1. Flow-through latency is 1 cycle.
- Bundle handshake: the whole bundle transfers when any valid_out is set and ready_in=1. If ready_in=1 but nothing is selectable, the bank loads empty and all valid_out go to 0.
- Per-FIFO available count:
  - count[f] = length of the contiguous valid prefix of valid_in[f] from slot 0.
  - A valid slot after a gap is ignored and is never popped.
- Selection, only when loadable and flush=0 and rst=0:
  - Visit FIFOs in order rr_ptr, rr_ptr+1, ... mod FIFOS, exactly once each.
  - Fill lanes 0.. in that order, taking slots 0..count[f]-1 from each FIFO visited.
  - Stop when OUTPUT_PORTS lanes are filled.
  - A FIFO may be partially drained; only the taken prefix is popped.
- pop[f][s]=1 exactly when slot s of FIFO f is placed in a lane this cycle. pop is combinational, same cycle as the load. pop is always a prefix per FIFO.
- Lane registers on load:
  - valid_out[l]=1 for l < number selected.
  - data_out/tag_out take the selected entry.
  - Unused lanes: valid 0; data and tag hold don't-care. Tests check only valid lanes.
- When not loadable (bundle held with ready_in=0): all registers hold and pop=0.
- Round-robin:
  - After a load with at least one pop, rr_ptr = (index of the last FIFO contributing an entry + 1) mod FIFOS.
  - Unchanged if nothing was popped.
  - With FIFOS=1, rr_ptr is always 0.
- Flush: valid_out cleared next cycle, pop=0 this cycle, rr_ptr unchanged. Flush overrides ready_in and any selectable data.
- rst asserted mid-bundle: next cycle all outputs and rr_ptr are at reset values; the pending bundle is lost. No pops occur during rst.
- Throughput: sustained OUTPUT_PORTS entries/cycle when ready_in=1 and enough entries are available.
- Ordering: lanes from the same FIFO keep slot order. A FIFO's entries never overtake its older entries across cycles.

Test Plan:
1. Reset, then idle (all valid_in=0, ready_in=1) -> pop=0, valid_out=00, rr_ptr=0 every cycle.
2. Defaults; FIFO0 slots {A0,A1} valid, FIFO1 {B0} valid, rr_ptr=0 -> pop[0]=11, pop[1]=00; next cycle data_out={A0,A1}, tag={0,0}, valid_out=11; rr_ptr=1.
3. Continue with FIFO0 refilled {A2,A3}, FIFO1 {B0} -> takes B0 then A2. pop[1]=01, pop[0]=01. Next cycle lanes {B0,A2}, tags {1,0}; rr_ptr=1.
4. Gap rule: FIFO0 valid_in=10 (slot1 only), FIFO1 empty -> pop=0, valid_out=00 after load; slot1 is never popped.
5. Backpressure: valid bundle {A0,A1}, ready_in=0 for 3 cycles with new heads present -> pop=0, outputs stable. On ready_in=1 the next entries load in that same cycle and appear 1 cycle later.
6. Flush and ready_in=1 together with selectable entries -> pop=0; valid_out=00 next cycle; rr_ptr unchanged. Then assert rst mid-bundle -> valid_out=00 and rr_ptr=0 on the following cycle.
